// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default timing constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   // Memory-wait tracking states
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam int unsigned MULT_CYCLES_DEF = 4;
   localparam int unsigned DIV_CYCLES_DEF  = 32;
   localparam int unsigned CNT_W_DEF       = 6;

endpackage

// File: rtl/md_sequencer.sv
// Mult/div busy sequencer: counts down the latency of the arithmetic unit
// and flags when HI/LO become valid.
module md_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic start_accept,
   input  logic is_div,
   output logic md_busy,
   output logic md_done
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next-state: load on accept, otherwise free-running countdown while busy
   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start_accept) begin
         cnt_d  = is_div ? DIV_LOAD : MULT_LOAD;
         busy_d = 1'b1;
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Sequencer registers; reset drops busy without a done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign md_busy = busy_q;
   assign md_done = done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: memory wait
// freeze, branch flush, mult/div interlock and load-use bubble.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_uses_hilo,
   input  logic       idex_re,
   input  logic [4:0] idex_dest,
   input  logic       ex_branch_taken,
   input  logic       ex_md_start,
   input  logic       ex_md_is_div,
   input  logic       exmem_mem_op,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       ifid_flush,
   output logic       idex_en,
   output logic       idex_flush,
   output logic       exmem_en,
   output logic       exmem_flush,
   output logic       memwb_flush,
   output logic       md_busy,
   output logic       md_done
);

   state_e state_q, state_d;
   logic   freeze;
   logic   load_use;
   logic   md_conflict;
   logic   seq_busy;
   logic   seq_done;
   logic   start_accept;

   // The completing cycle (mem_ready=1) lets the pipeline advance
   assign freeze = ((state_q == MEM_WAIT) || exmem_mem_op) && !mem_ready;

   assign load_use = idex_re && (idex_dest != 5'd0) &&
                     ((id_rs == idex_dest) || (id_uses_rt && (id_rt == idex_dest)));

   assign md_busy     = seq_busy && !reset;
   assign md_done     = seq_done && !reset;
   assign md_conflict = md_busy && (ex_md_start || id_uses_hilo);

   assign start_accept = ex_md_start && !md_busy && exmem_en && !freeze && !reset;

   // Memory-wait state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Memory-wait next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (exmem_mem_op && !mem_ready) state_d = MEM_WAIT;
         MEM_WAIT: if (mem_ready) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   // Prioritised stall/flush decode
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      if (reset) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (freeze) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (md_conflict) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         idex_en = 1'b0;
         if (ex_md_start) exmem_flush = 1'b1;
         else             idex_flush  = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   md_sequencer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_seq (
      .clock        (clock),
      .reset        (reset),
      .start_accept (start_accept),
      .is_div       (ex_md_is_div),
      .md_busy      (seq_busy),
      .md_done      (seq_done)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level model.
module tb_pipeline_hazard_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, idex_dest;
   logic       id_uses_rt, id_uses_hilo, idex_re, ex_branch_taken;
   logic       ex_md_start, ex_md_is_div, exmem_mem_op, mem_ready;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic       exmem_en, exmem_flush, memwb_flush, md_busy, md_done;
   logic [9:0] dut_vec;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // model state: memory wait flag and absolute cycles of the mult/div op
   bit waiting   = 1'b0;
   int start_cyc = -1000;
   int done_cyc  = -1000;

   always #5 clock = ~clock;

   pipeline_hazard_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_uses_hilo    (id_uses_hilo),
      .idex_re         (idex_re),
      .idex_dest       (idex_dest),
      .ex_branch_taken (ex_branch_taken),
      .ex_md_start     (ex_md_start),
      .ex_md_is_div    (ex_md_is_div),
      .exmem_mem_op    (exmem_mem_op),
      .mem_ready       (mem_ready),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_en         (idex_en),
      .idex_flush      (idex_flush),
      .exmem_en        (exmem_en),
      .exmem_flush     (exmem_flush),
      .memwb_flush     (memwb_flush),
      .md_busy         (md_busy),
      .md_done         (md_done)
   );

   // bit order: pc, ifid, ifid_fl, idex, idex_fl, exmem, exmem_fl, memwb_fl, busy, done
   assign dut_vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_flush, md_busy, md_done};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      else
         n_pass++;
   endtask

   function automatic bit m_busy();
      return (start_cyc < cyc) && (cyc < done_cyc);
   endfunction

   function automatic bit m_freeze();
      return (waiting || exmem_mem_op) && !mem_ready;
   endfunction

   function automatic logic [9:0] model_exp();
      bit pc, ifd, ifl, ide, ifx, exe, exf, mwf, bsy, dn, lu;
      bsy = m_busy();
      dn  = (cyc == done_cyc);
      if (reset) return 10'h0;
      {pc, ifd, ide, exe} = 4'b1111;
      {ifl, ifx, exf, mwf} = 4'b0000;
      lu = idex_re && idex_dest != 0 &&
           (id_rs == idex_dest || (id_uses_rt && id_rt == idex_dest));
      if (m_freeze()) begin
         {pc, ifd, ide, exe} = 4'b0000;
         mwf = 1;
      end else if (ex_branch_taken) begin
         ifl = 1; ifx = 1;
      end else if (bsy && ex_md_start) begin
         {pc, ifd, ide} = 3'b000;
         exf = 1;
      end else if (bsy && id_uses_hilo) begin
         {pc, ifd, ide} = 3'b000;
         ifx = 1;
      end else if (lu) begin
         pc = 0; ifd = 0; ifx = 1;
      end
      return {pc, ifd, ifl, ide, ifx, exe, exf, mwf, bsy, dn};
   endfunction

   // wait to mid-cycle and compare the DUT against the model
   task automatic sample();
      @(negedge clock);
      chk("model", 32'(dut_vec), 32'(model_exp()));
   endtask

   // apply the clock edge to the model, then to the DUT
   task automatic advance();
      logic [9:0] e;
      e = model_exp();
      if (reset) begin
         waiting   = 1'b0;
         start_cyc = -1000;
         done_cyc  = -1000;
      end else begin
         if (ex_md_start && !m_busy() && !m_freeze() && e[4]) begin
            start_cyc = cyc;
            done_cyc  = cyc + (ex_md_is_div ? 32 : 4);
         end
         waiting = waiting ? !mem_ready : (exmem_mem_op && !mem_ready);
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; idex_dest = 0;
      id_uses_rt = 0; id_uses_hilo = 0; idex_re = 0; ex_branch_taken = 0;
      ex_md_start = 0; ex_md_is_div = 0; exmem_mem_op = 0; mem_ready = 1;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      sample();
      chk("reset_outputs", 32'(dut_vec), 32'h0);
      advance();
      reset = 1'b0;
      sample(); advance();

      // load-use: exactly one bubble
      idex_re = 1; idex_dest = 5; id_rs = 5;
      sample();
      chk("lu_pc_en", 32'(pc_en), 0);
      chk("lu_ifid_en", 32'(ifid_en), 0);
      chk("lu_idex_flush", 32'(idex_flush), 1);
      advance();
      idex_re = 0;
      sample();
      chk("lu_after_en", 32'({pc_en, ifid_en, idex_en, exmem_en}), 32'hf);
      advance();

      // r0 destination never stalls
      idex_re = 1; idex_dest = 0; id_rs = 0;
      sample();
      chk("lu_r0_pc_en", 32'(pc_en), 1);
      advance();
      clear_inputs();

      // taken branch squashes a coincident load-use
      ex_branch_taken = 1; idex_re = 1; idex_dest = 7; id_rt = 7; id_uses_rt = 1;
      sample();
      chk("br_vec", 32'(dut_vec), 32'(10'b11_1_1_1_1_0_0_0_0));
      advance();
      clear_inputs();
      sample();
      chk("br_after_flush", 32'({ifid_flush, idex_flush}), 0);
      advance();

      // memory wait for 3 cycles with a branch held behind the freeze
      exmem_mem_op = 1; mem_ready = 0; ex_branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("mw_freeze", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_flush}), 32'h1);
         chk("mw_br_held", 32'(ifid_flush), 0);
         advance();
      end
      mem_ready = 1;
      sample();
      chk("mw_release", 32'({pc_en, exmem_en, memwb_flush, ifid_flush}), 32'b1101);
      advance();
      clear_inputs();

      // divide with an mfhi waiting in ID from cycle 5
      ex_md_start = 1; ex_md_is_div = 1;
      sample(); chk("div_busy0", 32'(md_busy), 0); advance();
      clear_inputs();
      for (int k = 1; k <= 32; k++) begin
         if (k == 5) id_uses_hilo = 1;
         sample();
         chk("div_busy", 32'(md_busy), 32'(k < 32));
         chk("div_done", 32'(md_done), 32'(k == 32));
         if (k >= 5) chk("div_hilo_stall", 32'({pc_en, idex_flush}), (k == 32) ? 32'b10 : 32'b01);
         advance();
      end
      clear_inputs();

      // back-to-back mult
      ex_md_start = 1;
      sample(); advance();
      for (int k = 1; k <= 4; k++) begin
         sample();
         chk("mm_exmem_flush", 32'(exmem_flush), 32'(k < 4));
         chk("mm_pc_en", 32'(pc_en), 32'(k == 4));
         chk("mm_done", 32'(md_done), 32'(k == 4));
         advance();
      end
      ex_md_start = 0;
      for (int k = 5; k <= 8; k++) begin
         sample();
         chk("mm2_busy", 32'(md_busy), 32'(k < 8));
         chk("mm2_done", 32'(md_done), 32'(k == 8));
         advance();
      end

      // reset in the middle of a divide
      ex_md_start = 1; ex_md_is_div = 1;
      sample(); advance();
      clear_inputs();
      for (int k = 1; k < 10; k++) begin sample(); advance(); end
      reset = 1; exmem_mem_op = 1; mem_ready = 0; ex_branch_taken = 1;
      sample();
      chk("rst_mid_outputs", 32'(dut_vec), 32'h0);
      advance();
      reset = 0; clear_inputs();
      for (int k = 0; k < 40; k++) begin
         sample();
         chk("rst_mid_md", 32'({md_busy, md_done}), 0);
         advance();
      end

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         reset           = ($urandom_range(99) == 0);
         id_rs           = 5'($urandom_range(7));
         id_rt           = 5'($urandom_range(7));
         idex_dest       = 5'($urandom_range(7));
         id_uses_rt      = 1'($urandom_range(1));
         id_uses_hilo    = ($urandom_range(99) < 15);
         idex_re         = ($urandom_range(99) < 30);
         ex_branch_taken = ($urandom_range(99) < 10);
         ex_md_start     = ($urandom_range(99) < 15);
         ex_md_is_div    = ($urandom_range(99) < 30);
         exmem_mem_op    = ($urandom_range(99) < 30);
         mem_ready       = ($urandom_range(99) < 60);
         sample();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions: load-use hazards, taken branches/jumps resolved in EX, data-memory wait states, and the multi-cycle mult/div unit. It also owns the mult/div busy sequencer that tracks HI/LO availability.

Parameters:
MULT_CYCLES, 4, cycles from an accepted mult start to md_done (min 2)
DIV_CYCLES, 32, cycles from an accepted div start to md_done (min 2)
CNT_W, 6, width of the mult/div countdown counter; must hold DIV_CYCLES

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_uses_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
idex_re  in  1  instruction in EX is a load
idex_dest  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  branch/jump in EX redirects the PC this cycle
ex_md_start  in  1  instruction in EX is mult/multu/div/divu
ex_md_is_div  in  1  1 = div/divu, 0 = mult/multu
exmem_mem_op  in  1  instruction in MEM is a load or store
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID loads a bubble
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX loads a bubble
exmem_en  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM loads a bubble
memwb_flush  out  1  MEM/WB loads a bubble
md_busy  out  1  mult/div in progress; HI/LO not valid
md_done  out  1  one-cycle pulse when HI/LO become valid

Behaviour:
- Reset: synchronous; the FSM and counter are sampled on the clock edge while reset=1. During any cycle with reset=1, all outputs are 0: enables 0, flushes 0, md_busy 0, md_done 0. The pipeline registers clear through their own reset.
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
  - RUN -> MEM_WAIT when exmem_mem_op=1 and mem_ready=0.
  - MEM_WAIT -> RUN on mem_ready=1.
- Freeze condition: state==MEM_WAIT, or the RUN entry condition holds. This is decided combinationally in the same cycle.
- Stall/flush outputs are combinational from state, counter and inputs, with zero latency. Evaluate in strict priority order; the first matching rule applies, and all unlisted enables=1 and flushes=0:
  1. Freeze: pc_en, ifid_en, idex_en and exmem_en = 0; memwb_flush = 1.
  2. ex_branch_taken: ifid_flush = 1 and idex_flush = 1. The PC loads the target, EX/MEM advances, and the branch itself completes.
  3. Mult/div conflict (md_busy=1 and either ex_md_start=1 or id_uses_hilo=1): pc_en, ifid_en and idex_en = 0. For ex_md_start, exmem_flush = 1. For id_uses_hilo only, idex_flush = 1 and EX advances.
  4. Load-use (idex_re=1, idex_dest!=0, and either id_rs==idex_dest or id_uses_rt&&id_rt==idex_dest): pc_en = 0, ifid_en = 0, idex_flush = 1. This gives exactly one bubble.
- Mult/div sequencer:
  - A start is accepted when ex_md_start=1, md_busy=0, exmem_en=1 and no freeze. On acceptance: counter <= (ex_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1, and md_busy <= 1 on the next edge.
  - While busy, the counter decrements every cycle, including during a freeze, because the arithmetic unit is free-running.
  - When busy and counter==1: at the next edge md_busy <= 0 and md_done <= 1 for one cycle.
  - md_done is registered.
  - A start arriving in the same cycle as md_done is accepted, since busy is already 0.
- Boundary conditions:
  - A branch during freeze is held and re-evaluated once the freeze clears.
  - A load-use condition that coincides with a branch is squashed by the branch flush.
  - idex_dest==0 never stalls.
  - If reset asserts mid-divide, md_busy clears with no md_done pulse.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum {RUN, MEM_WAIT} and the default MULT_CYCLES/DIV_CYCLES constants.
- One sub-module, md_sequencer: the counter, md_busy and md_done logic, with inputs start_accept and is_div.
- The hazard priority logic stays in the top level.

Test Plan:
- Load-use: lw with dest 5 in EX (idex_re=1, idex_dest=5) and add with rs=5 in ID. Required: pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; the next cycle all enables=1.
- Taken branch: ex_branch_taken=1 for 1 cycle. Required: ifid_flush=1, idex_flush=1, exmem_en=1, pc_en=1 in that cycle only.
- Memory wait: exmem_mem_op=1 with mem_ready=0 for 3 cycles, then 1. Required: freeze outputs (pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1) for 3 cycles, state MEM_WAIT on cycles 2-3, RUN after.
- Divide: accepted div start at cycle 0. Required: md_busy=1 on cycles 1..31, md_done=1 on cycle 32. An mfhi in ID at cycle 5 gives idex_flush=1 and pc_en=0 until cycle 32.
- Back-to-back mult: a second mult in EX while busy. Required: exmem_flush=1 and pc_en=0 until md_done. The second start is accepted that cycle, and a new md_done follows 4 cycles later.
- Reset mid-divide at cycle 10. Required: md_busy=0 and md_done stays 0 thereafter, and all outputs are 0 during the reset cycle.
